// File: rtl/tmept_loader.sv
// Boot-time program loader: parses checksummed frames from a byte stream, writes
// their payload into program RAM and holds the CPU in reset until the end command.
module tmept_loader #(
    parameter int unsigned TIMEOUT   = 65535,
    parameter logic [7:0]  SYNC_DATA = 8'hA5,
    parameter logic [7:0]  SYNC_END  = 8'h5A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        err_chk,
    output logic        err_timeout,
    output logic [7:0]  frames_ok
);

    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_ADDR_H = 3'd1,
        ST_ADDR_L = 3'd2,
        ST_LEN    = 3'd3,
        ST_DATA   = 3'd4,
        ST_CHK    = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

    // Running frame checksum: plain modulo-256 sum.
    function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
        chk_add = acc + b;
    endfunction

    state_t       state_r, state_s;
    logic [7:0]   sum_r;
    logic [15:0]  ptr_r;
    logic [8:0]   cnt_r;
    logic [15:0]  idle_r;
    logic         wr_en_r, cpu_hold_r, load_done_r, err_chk_r, err_timeout_r;
    logic [15:0]  wr_addr_r;
    logic [7:0]   wr_data_r, frames_ok_r;

    logic         rx_ready_s, accept_s, in_frame_s, timeout_s;
    logic         wr_fire_s, frame_good_s, frame_bad_s;
    logic [7:0]   sum_next_s;

    assign rx_ready_s = (state_r != ST_DONE);
    assign accept_s   = rx_valid & rx_ready_s;
    assign in_frame_s = (state_r != ST_HUNT) && (state_r != ST_DONE);
    // An accept in the expiry cycle wins over the timeout.
    assign timeout_s  = in_frame_s && !accept_s && (idle_r == IDLE_LAST);
    assign sum_next_s = chk_add(sum_r, rx_data);

    // Next-state and per-byte action decode.
    always_comb begin
        state_s      = state_r;
        wr_fire_s    = 1'b0;
        frame_good_s = 1'b0;
        frame_bad_s  = 1'b0;
        case (state_r)
            ST_HUNT: begin
                if (accept_s && rx_data == SYNC_DATA) begin
                    state_s = ST_ADDR_H;
                end else if (accept_s && rx_data == SYNC_END) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_HUNT;
                end
            end
            ST_ADDR_H: begin
                if (accept_s) state_s = ST_ADDR_L;
                else if (timeout_s) state_s = ST_HUNT;
                else state_s = ST_ADDR_H;
            end
            ST_ADDR_L: begin
                if (accept_s) state_s = ST_LEN;
                else if (timeout_s) state_s = ST_HUNT;
                else state_s = ST_ADDR_L;
            end
            ST_LEN: begin
                if (accept_s) state_s = ST_DATA;
                else if (timeout_s) state_s = ST_HUNT;
                else state_s = ST_LEN;
            end
            ST_DATA: begin
                if (accept_s) begin
                    wr_fire_s = 1'b1;
                    if (cnt_r == 9'd1) state_s = ST_CHK;
                    else state_s = ST_DATA;
                end else if (timeout_s) begin
                    state_s = ST_HUNT;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_CHK: begin
                if (accept_s) begin
                    state_s = ST_HUNT;
                    if (sum_next_s == 8'h00) frame_good_s = 1'b1;
                    else frame_bad_s = 1'b1;
                end else if (timeout_s) begin
                    state_s = ST_HUNT;
                end else begin
                    state_s = ST_CHK;
                end
            end
            ST_DONE: state_s = ST_DONE;
            default: state_s = ST_HUNT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_HUNT;
        else        state_r <= state_s;
    end

    // Frame datapath: checksum, pointer, remaining count and idle timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r  <= 8'h00;
            ptr_r  <= 16'h0000;
            cnt_r  <= 9'd0;
            idle_r <= 16'h0000;
        end else begin
            if (!in_frame_s || accept_s || timeout_s) idle_r <= 16'h0000;
            else                                      idle_r <= idle_r + 16'd1;
            if (accept_s) begin
                sum_r <= (state_r == ST_HUNT) ? 8'h00 : sum_next_s;
                case (state_r)
                    ST_ADDR_H: ptr_r[15:8] <= rx_data;
                    ST_ADDR_L: ptr_r[7:0]  <= rx_data;
                    ST_LEN:    cnt_r <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                    ST_DATA: begin
                        ptr_r <= ptr_r + 16'd1;
                        cnt_r <= cnt_r - 9'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Registered RAM write port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r       <= 1'b0;
            wr_addr_r     <= 16'h0000;
            wr_data_r     <= 8'h00;
            cpu_hold_r    <= 1'b1;
            load_done_r   <= 1'b0;
            err_chk_r     <= 1'b0;
            err_timeout_r <= 1'b0;
            frames_ok_r   <= 8'h00;
        end else begin
            wr_en_r <= wr_fire_s;
            if (wr_fire_s) begin
                wr_addr_r <= ptr_r;
                wr_data_r <= rx_data;
            end
            if (state_s == ST_DONE) begin
                cpu_hold_r  <= 1'b0;
                load_done_r <= 1'b1;
            end
            if (frame_bad_s) err_chk_r <= 1'b1;
            if (timeout_s)   err_timeout_r <= 1'b1;
            if (frame_good_s && frames_ok_r != 8'hFF) frames_ok_r <= frames_ok_r + 8'd1;
        end
    end

    assign rx_ready    = rx_ready_s;
    assign wr_en       = wr_en_r;
    assign wr_addr     = wr_addr_r;
    assign wr_data     = wr_data_r;
    assign cpu_hold    = cpu_hold_r;
    assign load_done   = load_done_r;
    assign err_chk     = err_chk_r;
    assign err_timeout = err_timeout_r;
    assign frames_ok   = frames_ok_r;

endmodule

// File: tb/tb_tmept_loader.sv
// Bench for tmept_loader: directed and random frames, expected writes and status
// derived from the frame format and checksum rule.
module tb_tmept_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, wr_en, cpu_hold, load_done, err_chk, err_timeout;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data, frames_ok;

    int   errors = 0;
    int   checks = 0;
    int   exp_ok = 0;
    logic exp_chk = 1'b0;
    logic exp_to = 1'b0;
    logic [7:0] payload [256];

    tmept_loader dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .load_done(load_done), .err_chk(err_chk),
        .err_timeout(err_timeout), .frames_ok(frames_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int gap_of(input bit gaps);
        gap_of = gaps ? int'($urandom_range(0, 3)) : 0;
    endfunction

    // Called at a negedge; presents one byte, checks the write it should (or should not) cause.
    task automatic send(input logic [7:0] b, input bit is_data, input logic [15:0] ea, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        chk("rx_ready", rx_ready, 1);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("wr_en", wr_en, is_data);
        if (is_data) begin
            chk("wr_addr", wr_addr, ea);
            chk("wr_data", wr_data, b);
        end
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            chk("wr_en_gap", wr_en, 0);
        end
    endtask

    task automatic send_frame(input logic [15:0] addr, input int len, input bit good, input bit gaps);
        logic [7:0] s, c, lb;
        lb = len[7:0];
        s = addr[15:8] + addr[7:0] + lb;
        for (int i = 0; i < len; i++) s = s + payload[i];
        c = 8'h00 - s;
        if (!good) c = c + 8'h01 + 8'($urandom_range(0, 254));
        send(8'hA5, 1'b0, 16'h0000, gap_of(gaps));
        send(addr[15:8], 1'b0, 16'h0000, gap_of(gaps));
        send(addr[7:0], 1'b0, 16'h0000, gap_of(gaps));
        send(lb, 1'b0, 16'h0000, gap_of(gaps));
        for (int i = 0; i < len; i++) send(payload[i], 1'b1, addr + 16'(i), gap_of(gaps));
        send(c, 1'b0, 16'h0000, gap_of(gaps));
        if (good) begin
            if (exp_ok < 255) exp_ok++;
        end else begin
            exp_chk = 1'b1;
        end
        chk("frames_ok", frames_ok, exp_ok);
        chk("err_chk", err_chk, exp_chk);
        chk("err_timeout", err_timeout, exp_to);
        chk("cpu_hold", cpu_hold, 1);
        chk("load_done", load_done, 0);
    endtask

    task automatic rand_payload(input int len);
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) payload[i] = ($urandom_range(0, 1) == 1) ? 8'hA5 : 8'h5A;
            else payload[i] = 8'($urandom);
        end
    endtask

    initial begin
        logic [7:0] g;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_cpu_hold", cpu_hold, 1);
        chk("rst_load_done", load_done, 0);
        chk("rst_err_chk", err_chk, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_frames_ok", frames_ok, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed good frame, then the same frame with a bad checksum
        payload[0] = 8'hAA;
        payload[1] = 8'hBB;
        send_frame(16'h1234, 2, 1'b1, 1'b0);
        send_frame(16'h1234, 2, 1'b0, 1'b0);

        // Address wrap and the 256-byte frame
        rand_payload(3);
        send_frame(16'hFFFF, 3, 1'b1, 1'b0);
        rand_payload(256);
        send_frame(16'(($urandom)), 256, 1'b1, 1'b0);

        // Random frames with gaps and inter-frame garbage, up to counter saturation
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                g = 8'($urandom);
                if (g == 8'hA5 || g == 8'h5A) g = 8'h00;
                send(g, 1'b0, 16'h0000, 0);
            end
            rand_payload(4);
            send_frame(16'($urandom), int'($urandom_range(1, 4)), ($urandom_range(0, 7) != 0), 1'b1);
        end
        while (exp_ok < 257) begin
            rand_payload(1);
            send_frame(16'($urandom), 1, 1'b1, 1'b0);
            if (exp_ok == 255) exp_ok = 257;
        end
        exp_ok = 255;
        rand_payload(1);
        send_frame(16'h0100, 1, 1'b1, 1'b0);
        chk("frames_ok_sat", frames_ok, 255);

        // Asynchronous reset while a write strobe is pending
        send(8'hA5, 1'b0, 16'h0000, 0);
        send(8'h00, 1'b0, 16'h0000, 0);
        send(8'h10, 1'b0, 16'h0000, 0);
        send(8'h02, 1'b0, 16'h0000, 0);
        send(8'h77, 1'b1, 16'h0010, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en", wr_en, 0);
        chk("arst_frames_ok", frames_ok, 0);
        chk("arst_err_chk", err_chk, 0);
        chk("arst_cpu_hold", cpu_hold, 1);
        @(negedge clk);
        rst_n = 1'b1;
        exp_ok = 0;
        exp_chk = 1'b0;
        exp_to = 1'b0;
        @(negedge clk);

        // Mid-frame stall: one cycle short of the limit, then the limit itself
        send(8'hA5, 1'b0, 16'h0000, 0);
        send(8'h12, 1'b0, 16'h0000, 0);
        send(8'h34, 1'b0, 16'h0000, 0);
        repeat (65534) @(negedge clk);
        chk("to_early", err_timeout, 0);
        @(negedge clk);
        chk("to_fire", err_timeout, 1);
        exp_to = 1'b1;
        send(8'h00, 1'b0, 16'h0000, 0);
        rand_payload(2);
        send_frame(16'h2000, 2, 1'b1, 1'b1);

        // End-of-load command and terminal DONE
        send(8'h11, 1'b0, 16'h0000, 0);
        send(8'h22, 1'b0, 16'h0000, 0);
        chk("hold_before_end", cpu_hold, 1);
        send(8'h5A, 1'b0, 16'h0000, 0);
        chk("end_cpu_hold", cpu_hold, 0);
        chk("end_load_done", load_done, 1);
        chk("end_rx_ready", rx_ready, 0);
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("done_wr_en", wr_en, 0);
            chk("done_rx_ready", rx_ready, 0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("final_rst_cpu_hold", cpu_hold, 1);
        chk("final_rst_load_done", load_done, 0);
        chk("final_rst_rx_ready", rx_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
